spi_byte_responder: RTL and testbench



---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_byte_responder.sv | 161 ++++++++++++++++
 tb/tb_spi_byte_responder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the responder and initiator sides.
// FSM encodings and the default MISO fill byte live here.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_e;

  localparam logic [7:0] SPI_IDLE_FILL = 8'hFF;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin,
// with rise/fall detection on the synchronized copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_byte_responder.sv
// SPI mode-0 byte responder: oversampled by clk, bytes in via
// rx FIFO write port, bytes out from a FWFT tx FIFO.
module spi_byte_responder
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_FILL   = SPI_IDLE_FILL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SPI_SCK,
  input  logic       SPI_MOSI,
  input  logic       SPI_CS_B,
  output logic       SPI_MISO,
  output logic       SPI_MISO_T,
  output logic [7:0] rx_data,
  output logic       rx_wren,
  input  logic       rx_full,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_read,
  output logic       cs_active,
  output logic       rx_overflow,
  output logic       frame_abort
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES);

  logic       w_sck_rise;
  logic       w_sck_fall;
  logic       w_mosi;
  logic       w_cs_b;
  logic [4:0] w_edges_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SPI_SCK),
    .o_sync (w_edges_unused[0]),
    .o_rise (w_sck_rise),
    .o_fall (w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SPI_MOSI),
    .o_sync (w_mosi),
    .o_rise (w_edges_unused[1]),
    .o_fall (w_edges_unused[2])
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SPI_CS_B),
    .o_sync (w_cs_b),
    .o_rise (w_edges_unused[3]),
    .o_fall (w_edges_unused[4])
  );

  spi_state_e r_state;
  spi_state_e w_next;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_data;
  logic       r_rx_wren;
  logic       r_ovf;
  logic       r_abort;
  logic       r_byte_done;
  logic       r_armed;
  logic [2:0] r_warm;

  logic w_start;
  logic w_cs_off;
  logic w_rise;
  logic w_complete;
  logic w_abort;
  logic w_tx_load;
  logic w_tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (r_armed && !w_cs_b) w_next = ST_LOAD;
      ST_LOAD:  w_next = w_cs_b ? ST_IDLE : ST_SHIFT;
      ST_SHIFT: if (w_cs_b) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign w_start    = (r_state == ST_IDLE) && r_armed && !w_cs_b;
  assign w_cs_off   = (r_state != ST_IDLE) && w_cs_b;
  assign w_rise     = (r_state == ST_SHIFT) && w_sck_rise;
  assign w_complete = w_rise && (r_bit_cnt == 3'd7);
  assign w_abort    = w_cs_off && (r_bit_cnt != 3'd0) && !w_complete;

  // The first fall after a finished byte fetches the next one.
  assign w_tx_load  = !w_cs_off &&
                      ((r_state == ST_LOAD) ||
                       ((r_state == ST_SHIFT) && w_sck_fall && r_byte_done));
  assign w_tx_shift = !w_cs_off && (r_state == ST_SHIFT) &&
                      w_sck_fall && !r_byte_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_tx_shift  <= IDLE_FILL;
      r_rx_data   <= 8'd0;
      r_rx_wren   <= 1'b0;
      r_ovf       <= 1'b0;
      r_abort     <= 1'b0;
      r_byte_done <= 1'b0;
      r_armed     <= 1'b0;
      r_warm      <= 3'd0;
    end else begin
      r_rx_wren <= w_complete && !rx_full;
      r_abort   <= w_abort;
      if (w_complete) r_rx_data <= {r_rx_shift[6:0], w_mosi};
      if (w_complete && rx_full) r_ovf <= 1'b1;
      else if (w_start)          r_ovf <= 1'b0;
      // Accept frames only after a genuine CS-high is seen post-reset.
      if (r_warm != WARM_MAX) r_warm <= r_warm + 3'd1;
      if ((r_warm == WARM_MAX) && w_cs_b) r_armed <= 1'b1;
      if (w_cs_off || (r_state == ST_LOAD)) begin
        r_bit_cnt   <= 3'd0;
        r_rx_shift  <= 8'd0;
        r_byte_done <= 1'b0;
      end else if (w_rise) begin
        r_rx_shift <= {r_rx_shift[6:0], w_mosi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) r_byte_done <= 1'b1;
      end else if (w_tx_load) begin
        r_byte_done <= 1'b0;
      end
      unique case (1'b1)
        w_tx_load:  r_tx_shift <= tx_valid ? tx_data : IDLE_FILL;
        w_tx_shift: r_tx_shift <= {r_tx_shift[6:0], 1'b1};
        default:    r_tx_shift <= r_tx_shift;
      endcase
    end
  end

  assign tx_read     = w_tx_load && tx_valid;
  assign SPI_MISO    = r_tx_shift[7];
  assign SPI_MISO_T  = (r_state == ST_IDLE);
  assign cs_active   = (r_state != ST_IDLE);
  assign rx_data     = r_rx_data;
  assign rx_wren     = r_rx_wren;
  assign rx_overflow = r_ovf;
  assign frame_abort = r_abort;

endmodule

// File: tb/tb_spi_byte_responder.sv
// Directed bench for spi_byte_responder: SPI master model,
// FWFT tx FIFO model and rx/tx/abort pulse monitor.
module tb_spi_byte_responder;

  logic       clk;
  logic       rst_n;
  logic       SPI_SCK;
  logic       SPI_MOSI;
  logic       SPI_CS_B;
  logic       SPI_MISO;
  logic       SPI_MISO_T;
  logic [7:0] rx_data;
  logic       rx_wren;
  logic       rx_full;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_read;
  logic       cs_active;
  logic       rx_overflow;
  logic       frame_abort;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_mem [0:511];
  logic [8:0] tx_wr = 9'd0;
  logic [8:0] tx_rd = 9'd0;

  logic [7:0] rx_log [0:1023];
  int rx_cnt    = 0;
  int txr_cnt   = 0;
  int abort_cnt = 0;

  spi_byte_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .SPI_SCK    (SPI_SCK),
    .SPI_MOSI   (SPI_MOSI),
    .SPI_CS_B   (SPI_CS_B),
    .SPI_MISO   (SPI_MISO),
    .SPI_MISO_T (SPI_MISO_T),
    .rx_data    (rx_data),
    .rx_wren    (rx_wren),
    .rx_full    (rx_full),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_read    (tx_read),
    .cs_active  (cs_active),
    .rx_overflow(rx_overflow),
    .frame_abort(frame_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign tx_valid = (tx_rd != tx_wr);
  assign tx_data  = tx_mem[tx_rd];

  always @(posedge clk) begin
    if (tx_read) tx_rd <= tx_rd + 9'd1;
  end

  always @(negedge clk) begin
    if (rx_wren) begin
      rx_log[rx_cnt] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_read) txr_cnt <= txr_cnt + 1;
    if (frame_abort) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] b);
    tx_mem[tx_wr] = b;
    tx_wr = tx_wr + 9'd1;
  endtask

  task automatic tx_flush();
    tx_wr = tx_rd;
  endtask

  task automatic cs_low();
    SPI_CS_B = 1'b0;
    clks(8);
  endtask

  task automatic cs_high();
    clks(4);
    SPI_CS_B = 1'b1;
    clks(8);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi);
    mi = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      SPI_MOSI = mo[7-i];
      clks(4);
      mi = {mi[6:0], SPI_MISO};
      SPI_SCK = 1'b1;
      clks(4);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic test_reset();
    SPI_SCK  = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_CS_B = 1'b1;
    rx_full  = 1'b0;
    rst_n    = 1'b0;
    clks(3);
    checks++;
    if ({rx_wren, tx_read, rx_overflow, frame_abort, cs_active,
         SPI_MISO, SPI_MISO_T} !== 7'b0000011) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000011",
               {rx_wren, tx_read, rx_overflow, frame_abort, cs_active,
                SPI_MISO, SPI_MISO_T});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    rst_n = 1'b1;
    clks(10);
  endtask

  task automatic test_single_byte();
    logic [7:0] mi;
    int rb;
    int tb0;
    tx_flush();
    tx_push(8'h3C);
    rb  = rx_cnt;
    tb0 = txr_cnt;
    cs_low();
    checks++;
    if ({cs_active, SPI_MISO_T} !== 2'b10) begin
      errors++;
      $display("FAIL single_active got %b want 10", {cs_active, SPI_MISO_T});
    end
    xfer(8'hA5, 8, mi);
    cs_high();
    checks++;
    if ({cs_active, SPI_MISO_T} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle got %b want 01", {cs_active, SPI_MISO_T});
    end
    checks++;
    if (rx_cnt - rb !== 1) begin
      errors++;
      $display("FAIL single_wren got %0d want 1", rx_cnt - rb);
    end
    checks++;
    if (rx_log[rb] !== 8'hA5) begin
      errors++;
      $display("FAIL single_rx got %h want a5", rx_log[rb]);
    end
    checks++;
    if (mi !== 8'h3C) begin
      errors++;
      $display("FAIL single_miso got %h want 3c", mi);
    end
    checks++;
    if (txr_cnt - tb0 !== 1) begin
      errors++;
      $display("FAIL single_txread got %0d want 1", txr_cnt - tb0);
    end
  endtask

  task automatic test_empty_tx();
    logic [7:0] mo [3];
    logic [7:0] mi;
    int rb;
    int tb0;
    mo[0] = 8'h11;
    mo[1] = 8'h22;
    mo[2] = 8'h33;
    tx_flush();
    rb  = rx_cnt;
    tb0 = txr_cnt;
    cs_low();
    for (int k = 0; k < 3; k++) begin
      xfer(mo[k], 8, mi);
      checks++;
      if (mi !== 8'hFF) begin
        errors++;
        $display("FAIL empty_miso byte %0d got %h want ff", k, mi);
      end
    end
    cs_high();
    checks++;
    if (rx_cnt - rb !== 3) begin
      errors++;
      $display("FAIL empty_wren got %0d want 3", rx_cnt - rb);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rx_log[rb+k] !== mo[k]) begin
        errors++;
        $display("FAIL empty_rx byte %0d got %h want %h",
                 k, rx_log[rb+k], mo[k]);
      end
    end
    checks++;
    if (txr_cnt - tb0 !== 0) begin
      errors++;
      $display("FAIL empty_txread got %0d want 0", txr_cnt - tb0);
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] mi;
    int rb;
    tx_flush();
    rb = rx_cnt;
    cs_low();
    xfer(8'hC1, 8, mi);
    rx_full = 1'b1;
    xfer(8'hC2, 8, mi);
    rx_full = 1'b0;
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf_set got %b want 1", rx_overflow);
    end
    xfer(8'hC3, 8, mi);
    cs_high();
    checks++;
    if (rx_cnt - rb !== 2) begin
      errors++;
      $display("FAIL bp_wren got %0d want 2", rx_cnt - rb);
    end
    checks++;
    if ({rx_log[rb], rx_log[rb+1]} !== 16'hC1C3) begin
      errors++;
      $display("FAIL bp_rx got %h%h want c1c3", rx_log[rb], rx_log[rb+1]);
    end
    checks++;
    if (rx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_ovf_sticky got %b want 1", rx_overflow);
    end
    cs_low();
    checks++;
    if (rx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL bp_ovf_clear got %b want 0", rx_overflow);
    end
    cs_high();
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    int rb;
    int ab;
    tx_flush();
    rb = rx_cnt;
    ab = abort_cnt;
    cs_low();
    xfer(8'h5A, 5, mi);
    cs_high();
    checks++;
    if (abort_cnt - ab !== 1) begin
      errors++;
      $display("FAIL abort_pulse got %0d want 1", abort_cnt - ab);
    end
    checks++;
    if (rx_cnt - rb !== 0) begin
      errors++;
      $display("FAIL abort_wren got %0d want 0", rx_cnt - rb);
    end
    tx_push(8'hE7);
    cs_low();
    xfer(8'h96, 8, mi);
    cs_high();
    checks++;
    if ((rx_cnt - rb !== 1) || (rx_log[rb] !== 8'h96)) begin
      errors++;
      $display("FAIL abort_next_rx got %h (n=%0d) want 96 (n=1)",
               rx_log[rb], rx_cnt - rb);
    end
    checks++;
    if (mi !== 8'hE7) begin
      errors++;
      $display("FAIL abort_next_miso got %h want e7", mi);
    end
    checks++;
    if (abort_cnt - ab !== 1) begin
      errors++;
      $display("FAIL abort_clean got %0d want 1", abort_cnt - ab);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    int rb;
    tx_flush();
    rb = rx_cnt;
    cs_low();
    rx_full = 1'b1;
    xfer(8'h44, 8, mi);
    rx_full = 1'b0;
    xfer(8'h55, 4, mi);
    rst_n = 1'b0;
    clks(2);
    checks++;
    if ({rx_wren, tx_read, rx_overflow, frame_abort, cs_active,
         SPI_MISO, SPI_MISO_T} !== 7'b0000011) begin
      errors++;
      $display("FAIL rstmid_outputs got %b want 0000011",
               {rx_wren, tx_read, rx_overflow, frame_abort, cs_active,
                SPI_MISO, SPI_MISO_T});
    end
    rst_n = 1'b1;
    clks(2);
    xfer(8'h55, 4, mi);
    xfer(8'h66, 8, mi);
    checks++;
    if ({cs_active, SPI_MISO_T} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_ignored got %b want 01", {cs_active, SPI_MISO_T});
    end
    checks++;
    if (rx_cnt - rb !== 0) begin
      errors++;
      $display("FAIL rstmid_wren got %0d want 0", rx_cnt - rb);
    end
    cs_high();
    tx_push(8'hB4);
    cs_low();
    xfer(8'h77, 8, mi);
    cs_high();
    checks++;
    if ((rx_cnt - rb !== 1) || (rx_log[rb] !== 8'h77)) begin
      errors++;
      $display("FAIL rstmid_next_rx got %h (n=%0d) want 77 (n=1)",
               rx_log[rb], rx_cnt - rb);
    end
    checks++;
    if (mi !== 8'hB4) begin
      errors++;
      $display("FAIL rstmid_next_miso got %h want b4", mi);
    end
  endtask

  task automatic test_rate();
    logic [7:0] mi;
    logic [7:0] exp_mi;
    int rb;
    int tb0;
    tx_flush();
    for (int i = 0; i < 256; i++) tx_push(8'(i + 8'h40));
    rb  = rx_cnt;
    tb0 = txr_cnt;
    cs_low();
    for (int i = 0; i < 256; i++) begin
      xfer(8'(i), 8, mi);
      exp_mi = 8'(i + 8'h40);
      checks++;
      if (mi !== exp_mi) begin
        errors++;
        $display("FAIL rate_miso byte %0d got %h want %h", i, mi, exp_mi);
      end
    end
    cs_high();
    checks++;
    if (rx_cnt - rb !== 256) begin
      errors++;
      $display("FAIL rate_wren got %0d want 256", rx_cnt - rb);
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (rx_log[rb+i] !== 8'(i)) begin
        errors++;
        $display("FAIL rate_rx byte %0d got %h want %h",
                 i, rx_log[rb+i], 8'(i));
      end
    end
    checks++;
    if (txr_cnt - tb0 !== 256) begin
      errors++;
      $display("FAIL rate_txread got %0d want 256", txr_cnt - tb0);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_empty_tx();
    test_back_pressure();
    test_abort();
    test_reset_mid();
    test_rate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
